// File: rtl/mem_ctrl_if.sv
// Data-bus side of the load/store controller:
// req/gnt address phase plus rvalid read-data return.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_gnt_i;
  logic              bus_rvalid_i;
  logic [DATA_W-1:0] bus_rdata_i;

  modport master (
    output bus_req_o,
    output bus_we_o,
    output bus_addr_o,
    output bus_wdata_o,
    input  bus_gnt_i,
    input  bus_rvalid_i,
    input  bus_rdata_i
  );

  modport slave (
    input  bus_req_o,
    input  bus_we_o,
    input  bus_addr_o,
    input  bus_wdata_o,
    output bus_gnt_i,
    output bus_rvalid_i,
    output bus_rdata_i
  );
endinterface

// File: rtl/mem_ctrl.sv
// Load/store bus controller: turns ex's mem request into a
// req/gnt/rvalid bus transaction and stalls the pipe until done.
module mem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              hold_o,
  output logic              err_o,
  mem_ctrl_if.master        bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              breq_q, breq_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              expired;

  assign expired = (cnt_q == CNT_LAST);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    breq_d  = breq_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = we_i ? waddr_i : raddr_i;
          wdata_d = wdata_i;
          cnt_d   = '0;
          breq_d  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.bus_gnt_i) begin
          cnt_d  = '0;
          breq_d = 1'b0;
          if (we_q) begin
            state_d = DONE;
          end else if (bus.bus_rvalid_i) begin
            rdata_d = bus.bus_rdata_i;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end else if (expired) begin
          breq_d  = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT: begin
        if (bus.bus_rvalid_i) begin
          rdata_d = bus.bus_rdata_i;
          state_d = DONE;
        end else if (expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      breq_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      breq_q  <= breq_d;
      cnt_q   <= cnt_d;
    end
  end

  // IDLE stalls combinationally so ex never advances past a fresh request
  assign hold_o = !rst && ((state_q == IDLE) ? req_i
                                             : (state_q != DONE));

  assign rdata_o         = rdata_q;
  assign err_o           = err_q;
  assign bus.bus_req_o   = breq_q;
  assign bus.bus_we_o    = breq_q & we_q;
  assign bus.bus_addr_o  = {ADDR_W{breq_q}} & addr_q;
  assign bus.bus_wdata_o = {DATA_W{breq_q}} & wdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed vector table, reset-in-WAIT
// sequence, then randomized accesses against a latency model.
module tb_mem_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_i;
  logic          we_i;
  logic [AW-1:0] raddr_i;
  logic [AW-1:0] waddr_i;
  logic [DW-1:0] wdata_i;
  logic [DW-1:0] rdata_o;
  logic          hold_o;
  logic          err_o;

  mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .we_i    (we_i),
    .raddr_i (raddr_i),
    .waddr_i (waddr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .hold_o  (hold_o),
    .err_o   (err_o),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_rdata;
  logic        m_err;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          g;
    int          r;
    logic [31:0] data;
    int          gap;
    int          hold;
    int          reqn;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Latency and result of one access from the gnt/rvalid delays
  task automatic model(input logic we, input int g, input int r,
                       input logic [31:0] data,
                       output int hold, output int reqn);
    int w;
    bit to;
    w  = 0;
    to = 0;
    if (g >= TO) begin
      reqn = TO;
      to   = 1;
    end else begin
      reqn = g + 1;
      if (!we && r > 0) begin
        if (r > TO) begin
          w  = TO;
          to = 1;
        end else begin
          w = r;
        end
      end
    end
    hold = 1 + reqn + w;
    if (to) begin
      m_rdata = 0;
      m_err   = 1;
    end else if (!we) begin
      m_rdata = data;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      req_i            = 1'b0;
      raddr_i          = $urandom;
      bus.bus_gnt_i    = 1'($urandom);
      bus.bus_rvalid_i = 1'($urandom);
      bus.bus_rdata_i  = $urandom;
      #1;
      chk("idle_hold", hold_o, 1'b0);
      chk("idle_bus_req", bus.bus_req_o, 1'b0);
    end
  endtask

  task automatic access(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int g,
                        input int r, input logic [31:0] data,
                        input int exp_hold, input int exp_req,
                        input logic [31:0] exp_rd, input logic exp_err);
    int hold_n   = 0;
    int req_n    = 0;
    int req_seen = 0;
    int since    = 0;
    bit gave     = 0;
    bit done     = 0;
    @(negedge clk);
    req_i            = 1'b1;
    we_i             = we;
    raddr_i          = we ? $urandom : addr;
    waddr_i          = we ? addr : $urandom;
    wdata_i          = wdata;
    bus.bus_gnt_i    = 1'b0;
    bus.bus_rvalid_i = 1'b0;
    bus.bus_rdata_i  = $urandom;
    for (int k = 0; k < 60 && !done; k++) begin
      if (k > 0) begin
        @(negedge clk);
        raddr_i          = $urandom;
        waddr_i          = $urandom;
        wdata_i          = $urandom;
        we_i             = 1'($urandom);
        bus.bus_gnt_i    = 1'b0;
        bus.bus_rvalid_i = 1'b0;
        bus.bus_rdata_i  = $urandom;
        if (bus.bus_req_o) begin
          if (req_seen == g) begin
            bus.bus_gnt_i = 1'b1;
            gave          = 1;
            if (r == 0) begin
              bus.bus_rvalid_i = 1'b1;
              bus.bus_rdata_i  = data;
            end
          end
          req_seen++;
        end else if (gave && !we) begin
          since++;
          if (since == r) begin
            bus.bus_rvalid_i = 1'b1;
            bus.bus_rdata_i  = data;
          end
        end
      end
      #1;
      if (hold_o) begin
        hold_n++;
        if (bus.bus_req_o) begin
          req_n++;
          chk("bus_addr", bus.bus_addr_o, addr);
          chk("bus_we", bus.bus_we_o, we);
          chk("bus_wdata", bus.bus_wdata_o, wdata);
        end
      end else begin
        done = 1;
        chk("done_rdata", rdata_o, exp_rd);
        chk("done_err", err_o, exp_err);
        chk("done_bus_req", bus.bus_req_o, 1'b0);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_bound: got no DONE expected DONE in 60 cycles");
    end
    chk("hold_cycles", hold_n, exp_hold);
    chk("req_cycles", req_n, exp_req);
  endtask

  initial begin
    int eh;
    int er;
    tbl[0] = '{1'b0, 32'h100, 32'h0,        0, 1,
               32'hDEADBEEF, 1, 3, 1, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{1'b1, 32'h104, 32'h12345678, 3, 5,
               32'h0, 1, 5, 4, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b0, 32'h108, 32'h77,       0, 0,
               32'hCAFEF00D, 0, 2, 1, 32'hCAFEF00D, 1'b0};
    tbl[3] = '{1'b0, 32'h10C, 32'h0,        2, 16,
               32'h0BADF00D, 2, 20, 3, 32'h0BADF00D, 1'b0};
    tbl[4] = '{1'b1, 32'h110, 32'hA5A5A5A5, 15, 0,
               32'h0, 0, 17, 16, 32'h0BADF00D, 1'b0};
    tbl[5] = '{1'b0, 32'h200, 32'h0,        20, 1,
               32'hFFFF, 1, 17, 16, 32'h0, 1'b1};
    tbl[6] = '{1'b0, 32'h20C, 32'h0,        1, 17,
               32'h99, 0, 19, 2, 32'h0, 1'b1};
    tbl[7] = '{1'b0, 32'h204, 32'h0,        0, 1,
               32'h11223344, 0, 3, 1, 32'h11223344, 1'b1};
    tbl[8] = '{1'b1, 32'h208, 32'h55667788, 0, 2,
               32'h0, 0, 2, 1, 32'h11223344, 1'b1};

    rst              = 1'b1;
    req_i            = 1'b1;
    we_i             = 1'b0;
    raddr_i          = 32'h40;
    waddr_i          = 32'h0;
    wdata_i          = 32'h0;
    bus.bus_gnt_i    = 1'b0;
    bus.bus_rvalid_i = 1'b0;
    bus.bus_rdata_i  = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold", hold_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_bus_req", bus.bus_req_o, 1'b0);
    chk("rst_bus_we", bus.bus_we_o, 1'b0);
    chk("rst_bus_addr", bus.bus_addr_o, 32'h0);
    chk("rst_bus_wdata", bus.bus_wdata_o, 32'h0);
    req_i = 1'b0;
    rst   = 1'b0;

    for (int i = 0; i < 9; i++) begin
      idle(tbl[i].gap);
      access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].g, tbl[i].r,
             tbl[i].data, tbl[i].hold, tbl[i].reqn, tbl[i].rd,
             tbl[i].err);
    end

    @(negedge clk);
    req_i            = 1'b1;
    we_i             = 1'b0;
    raddr_i          = 32'h300;
    bus.bus_gnt_i    = 1'b0;
    bus.bus_rvalid_i = 1'b0;
    @(negedge clk);
    #1;
    chk("seq_req", bus.bus_req_o, 1'b1);
    bus.bus_gnt_i = 1'b1;
    @(negedge clk);
    bus.bus_gnt_i = 1'b0;
    #1;
    chk("seq_wait_hold", hold_o, 1'b1);
    chk("seq_wait_req", bus.bus_req_o, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_hold", hold_o, 1'b0);
    chk("async_rdata", rdata_o, 32'h0);
    chk("async_err", err_o, 1'b0);
    chk("async_bus_req", bus.bus_req_o, 1'b0);
    chk("async_bus_addr", bus.bus_addr_o, 32'h0);
    @(negedge clk);
    req_i = 1'b0;
    rst   = 1'b0;
    bus.bus_rvalid_i = 1'b1;
    bus.bus_rdata_i  = 32'hFFFFFFFF;
    @(negedge clk);
    bus.bus_rvalid_i = 1'b0;
    #1;
    chk("late_rvalid_rdata", rdata_o, 32'h0);
    chk("late_rvalid_hold", hold_o, 1'b0);
    chk("late_rvalid_req", bus.bus_req_o, 1'b0);
    m_rdata = 32'h0;
    m_err   = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic        we;
      int          g;
      int          r;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] data;
      we    = 1'($urandom);
      g     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18))
                                          : int'($urandom_range(0, 3));
      r     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 18))
                                          : int'($urandom_range(0, 3));
      addr  = $urandom;
      wdata = $urandom;
      data  = $urandom;
      idle(int'($urandom_range(0, 2)));
      model(we, g, r, data, eh, er);
      access(we, addr, wdata, g, r, data, eh, er, m_rdata, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
